// File: rtl/rv32i_trace_buffer.sv
// rv32i_trace_buffer: writeback trace capture for the rv32i core.
// Timestamps every architectural register write (rd != x0), queues it in a
// FIFO and streams each record as a two-word valid/ready packet:
//   word0 = {ts[15:0], 11'b0, rd[4:0]}, word1 = data[31:0] (last=1).
module rv32i_trace_buffer #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enable_i,
    input  logic          clear_i,
    input  logic          wb_valid_i,
    input  logic [4:0]    wb_rd_i,
    input  logic [31:0]   wb_data_i,
    output logic          trace_valid_o,
    input  logic          trace_ready_i,
    output logic [31:0]   trace_data_o,
    output logic          trace_last_o,
    output logic [AW:0]   level_o,
    output logic [15:0]   drop_cnt_o,
    output logic          overflow_o
);

    localparam logic [AW:0] LevelFull = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StHdr, StDat} state_e;

    // Record storage, split by field
    logic [15:0]   mem_ts_q   [DEPTH];
    logic [4:0]    mem_rd_q   [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];

    logic [15:0]   ts_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic [15:0]   drop_cnt_q;
    logic          overflow_q;

    state_e        state_q;
    logic          valid_q;
    logic          last_q;
    logic [31:0]   data_q;
    logic [31:0]   hold_q;   // data word of the record currently being sent

    logic          capture;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [31:0]   head_word0;
    logic [31:0]   head_data;

    // Capture/pop decisions and FIFO level next-state
    always_comb begin
        capture = enable_i & wb_valid_i & (wb_rd_i != 5'd0) & ~clear_i;
        empty   = (level_q == '0);
        full    = (level_q == LevelFull);
        // The FSM takes a new record when idle, or right as the data word of
        // the current packet is accepted, so packets run back-to-back.
        pop     = ~clear_i & ~empty &
                  ((state_q == StIdle) | ((state_q == StDat) & trace_ready_i));
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        push    = capture & (~full | pop);
        drop    = capture & full & ~pop;

        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        head_word0 = {mem_ts_q[rd_ptr_q], 11'b0, mem_rd_q[rd_ptr_q]};
        head_data  = mem_data_q[rd_ptr_q];
    end

    // Free-running timestamp; frozen while capture is disabled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q <= 16'd0;
        end else if (clear_i) begin
            ts_q <= 16'd0;
        end else if (enable_i) begin
            ts_q <= ts_q + 16'd1;
        end
    end

    // Record storage write; contents need no reset, validity is tracked by level
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_ts_q[wr_ptr_q]   <= ts_q;
            mem_rd_q[wr_ptr_q]   <= wb_rd_i;
            mem_data_q[wr_ptr_q] <= wb_data_i;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

    // Saturating drop counter and sticky overflow flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= 16'd0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            drop_cnt_q <= 16'd0;
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    // Output packet FSM with registered valid/data/last
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= 32'd0;
            hold_q  <= 32'd0;
        end else if (clear_i) begin
            // Abandon any half-sent packet
            state_q <= StIdle;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q <= StHdr;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        data_q  <= head_word0;
                        hold_q  <= head_data;
                    end
                end
                StHdr: begin
                    if (trace_ready_i) begin
                        state_q <= StDat;
                        last_q  <= 1'b1;
                        data_q  <= hold_q;
                    end
                end
                StDat: begin
                    if (trace_ready_i) begin
                        if (pop) begin
                            state_q <= StHdr;
                            valid_q <= 1'b1;
                            last_q  <= 1'b0;
                            data_q  <= head_word0;
                            hold_q  <= head_data;
                        end else begin
                            state_q <= StIdle;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            data_q  <= 32'd0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    data_q  <= 32'd0;
                end
            endcase
        end
    end

    assign trace_valid_o = valid_q;
    assign trace_data_o  = data_q;
    assign trace_last_o  = last_q;
    assign level_o       = level_q;
    assign drop_cnt_o    = drop_cnt_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_rv32i_trace_buffer.sv
// Directed testbench for rv32i_trace_buffer (DEPTH=16).
module tb_rv32i_trace_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic        clear_i;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_data_o;
    logic        trace_last_o;
    logic [4:0]  level_o;
    logic [15:0] drop_cnt_o;
    logic        overflow_o;

    int errors = 0;
    int checks = 0;
    logic [15:0] ts_m;   // expected timestamp register value

    rv32i_trace_buffer #(.DEPTH(16)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .clear_i       (clear_i),
        .wb_valid_i    (wb_valid_i),
        .wb_rd_i       (wb_rd_i),
        .wb_data_i     (wb_data_i),
        .trace_valid_o (trace_valid_o),
        .trace_ready_i (trace_ready_i),
        .trace_data_o  (trace_data_o),
        .trace_last_o  (trace_last_o),
        .level_o       (level_o),
        .drop_cnt_o    (drop_cnt_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock edge; inputs then outputs are observed 1 time unit after it
    task automatic tick();
        @(posedge clk_i);
        if (!rst_ni || clear_i) ts_m = 16'd0;
        else if (enable_i) ts_m = ts_m + 16'd1;
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_i = 1'b0;
        wb_valid_i = 1'b0;
        wb_rd_i = 5'd0;
        wb_data_i = 32'd0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        ts_m = 16'd0;
    endtask

    task automatic test_reset();
        bit seen;
        enable_i = 1'b0; trace_ready_i = 1'b1;
        rst_ni = 1'b0; clear_i = 1'b0; wb_valid_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'd0;
        ts_m = 16'd0;
        #23;
        checks++; if (trace_valid_o !== 1'b0) begin errors++;
            $display("FAIL reset_valid got=%b exp=0", trace_valid_o); end
        checks++; if (trace_data_o !== 32'd0) begin errors++;
            $display("FAIL reset_data got=%h exp=0", trace_data_o); end
        checks++; if (trace_last_o !== 1'b0) begin errors++;
            $display("FAIL reset_last got=%b exp=0", trace_last_o); end
        checks++; if (level_o !== 5'd0) begin errors++;
            $display("FAIL reset_level got=%0d exp=0", level_o); end
        checks++; if (drop_cnt_o !== 16'd0) begin errors++;
            $display("FAIL reset_drop got=%0d exp=0", drop_cnt_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++;
            $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        enable_i = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (trace_valid_o !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++;
            $display("FAIL idle_valid got=1 exp=0 (valid asserted without activity)"); end
    endtask

    task automatic test_single();
        enable_i = 1'b1; trace_ready_i = 1'b1;
        do_reset();
        repeat (5) tick();
        wb_valid_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'hDEADBEEF;
        tick();
        wb_valid_i = 1'b0;
        checks++; if (level_o !== 5'd1 || trace_valid_o !== 1'b0) begin errors++;
            $display("FAIL single_capture level=%0d valid=%b exp level=1 valid=0",
                     level_o, trace_valid_o); end
        tick();
        checks++; if (trace_valid_o !== 1'b1 || trace_data_o !== 32'h00050003
                      || trace_last_o !== 1'b0) begin errors++;
            $display("FAIL single_word0 valid=%b data=%h last=%b exp 1/00050003/0",
                     trace_valid_o, trace_data_o, trace_last_o); end
        checks++; if (level_o !== 5'd0) begin errors++;
            $display("FAIL single_level_after_pop got=%0d exp=0", level_o); end
        tick();
        checks++; if (trace_valid_o !== 1'b1 || trace_data_o !== 32'hDEADBEEF
                      || trace_last_o !== 1'b1) begin errors++;
            $display("FAIL single_word1 valid=%b data=%h last=%b exp 1/deadbeef/1",
                     trace_valid_o, trace_data_o, trace_last_o); end
        tick();
        checks++; if (trace_valid_o !== 1'b0) begin errors++;
            $display("FAIL single_end_valid got=%b exp=0", trace_valid_o); end
    endtask

    task automatic test_x0_backpressure();
        logic [15:0] exp_ts;
        logic [31:0] w0;
        logic [4:0]  peak;
        enable_i = 1'b1; trace_ready_i = 1'b0;
        do_reset();
        repeat (2) tick();
        wb_valid_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'hAAAA5555;
        tick();
        checks++; if (level_o !== 5'd0) begin errors++;
            $display("FAIL x0_not_recorded level=%0d exp=0", level_o); end
        wb_rd_i = 5'd7; wb_data_i = 32'h12345678; exp_ts = ts_m;
        tick();
        wb_valid_i = 1'b0;
        peak = level_o;
        tick();
        w0 = {exp_ts, 11'b0, 5'd7};
        checks++; if (trace_valid_o !== 1'b1 || trace_data_o !== w0) begin errors++;
            $display("FAIL bp_word0 valid=%b data=%h exp 1/%h", trace_valid_o, trace_data_o, w0); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (level_o > peak) peak = level_o;
            checks++; if (trace_valid_o !== 1'b1 || trace_data_o !== w0 || trace_last_o !== 1'b0)
            begin errors++;
                $display("FAIL bp_hold cycle=%0d valid=%b data=%h last=%b exp 1/%h/0",
                         i, trace_valid_o, trace_data_o, trace_last_o, w0); end
        end
        checks++; if (peak !== 5'd1) begin errors++;
            $display("FAIL bp_level_peak got=%0d exp=1", peak); end
        trace_ready_i = 1'b1;
        tick();
        checks++; if (trace_data_o !== 32'h12345678 || trace_last_o !== 1'b1) begin errors++;
            $display("FAIL bp_word1 data=%h last=%b exp 12345678/1", trace_data_o, trace_last_o); end
        tick();
        checks++; if (trace_valid_o !== 1'b0) begin errors++;
            $display("FAIL bp_end_valid got=%b exp=0", trace_valid_o); end
        // Capture disabled: nothing recorded
        enable_i = 1'b0;
        wb_valid_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h0BADF00D;
        tick();
        wb_valid_i = 1'b0;
        checks++; if (level_o !== 5'd0) begin errors++;
            $display("FAIL disabled_capture level=%0d exp=0", level_o); end
        tick();
        checks++; if (trace_valid_o !== 1'b0) begin errors++;
            $display("FAIL disabled_valid got=%b exp=0", trace_valid_o); end
    endtask

    task automatic test_overflow();
        logic [15:0] ts0;
        logic [15:0] t;
        logic [31:0] exp_d;
        logic        exp_l;
        int          r;
        enable_i = 1'b1; trace_ready_i = 1'b0;
        do_reset();
        tick();
        ts0 = ts_m;
        for (int i = 0; i < 20; i++) begin
            wb_valid_i = 1'b1; wb_rd_i = 5'(i + 1); wb_data_i = 32'h1000 + i;
            tick();
        end
        wb_valid_i = 1'b0;
        checks++; if (level_o !== 5'd16) begin errors++;
            $display("FAIL ovf_level got=%0d exp=16", level_o); end
        checks++; if (drop_cnt_o !== 16'd3) begin errors++;
            $display("FAIL ovf_drop_cnt got=%0d exp=3", drop_cnt_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++;
            $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
        trace_ready_i = 1'b1;
        for (int w = 0; w < 34; w++) begin
            r = w / 2;
            t = ts0 + 16'(r);
            exp_d = (w % 2 == 0) ? {t, 11'b0, 5'(r + 1)} : 32'h1000 + r;
            exp_l = (w % 2 == 1);
            checks++; if (trace_valid_o !== 1'b1 || trace_data_o !== exp_d
                          || trace_last_o !== exp_l) begin errors++;
                $display("FAIL drain_word%0d valid=%b data=%h last=%b exp 1/%h/%b",
                         w, trace_valid_o, trace_data_o, trace_last_o, exp_d, exp_l); end
            tick();
        end
        checks++; if (trace_valid_o !== 1'b0 || level_o !== 5'd0) begin errors++;
            $display("FAIL drain_end valid=%b level=%0d exp 0/0", trace_valid_o, level_o); end
    endtask

    // Runs after test_overflow so the drop counter starts non-zero
    task automatic test_clear();
        enable_i = 1'b1; trace_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wb_valid_i = 1'b1; wb_rd_i = 5'(10 + i); wb_data_i = 32'h2000 + i;
            tick();
        end
        wb_valid_i = 1'b0;
        trace_ready_i = 1'b1;
        tick();
        checks++; if (trace_valid_o !== 1'b1 || trace_last_o !== 1'b1 || level_o !== 5'd5
                      || drop_cnt_o !== 16'd3) begin errors++;
            $display("FAIL clear_pre valid=%b last=%b level=%0d drop=%0d exp 1/1/5/3",
                     trace_valid_o, trace_last_o, level_o, drop_cnt_o); end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        checks++; if (trace_valid_o !== 1'b0 || level_o !== 5'd0) begin errors++;
            $display("FAIL clear_post valid=%b level=%0d exp 0/0", trace_valid_o, level_o); end
        checks++; if (drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin errors++;
            $display("FAIL clear_drop drop=%0d ovf=%b exp 0/0", drop_cnt_o, overflow_o); end
        wb_valid_i = 1'b1; wb_rd_i = 5'd9; wb_data_i = 32'hCAFEF00D;
        tick();
        wb_valid_i = 1'b0;
        tick();
        checks++; if (trace_valid_o !== 1'b1 || trace_data_o !== 32'h00000009) begin errors++;
            $display("FAIL clear_ts valid=%b data=%h exp 1/00000009", trace_valid_o, trace_data_o); end
        tick();
        checks++; if (trace_data_o !== 32'hCAFEF00D || trace_last_o !== 1'b1) begin errors++;
            $display("FAIL clear_word1 data=%h last=%b exp cafef00d/1", trace_data_o, trace_last_o); end
        tick();
    endtask

    task automatic test_wrap_async();
        bit seen;
        enable_i = 1'b1; trace_ready_i = 1'b0;
        do_reset();
        repeat (65539) tick();
        wb_valid_i = 1'b1; wb_rd_i = 5'd4; wb_data_i = 32'h55AA55AA;
        tick();
        wb_valid_i = 1'b0;
        tick();
        checks++; if (trace_valid_o !== 1'b1 || trace_data_o !== 32'h00030004) begin errors++;
            $display("FAIL wrap_word0 valid=%b data=%h exp 1/00030004", trace_valid_o, trace_data_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (trace_valid_o !== 1'b0 || trace_data_o !== 32'd0 || trace_last_o !== 1'b0)
        begin errors++;
            $display("FAIL async_reset valid=%b data=%h last=%b exp 0/0/0",
                     trace_valid_o, trace_data_o, trace_last_o); end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        ts_m = 16'd0;
        trace_ready_i = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (trace_valid_o !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || level_o !== 5'd0) begin errors++;
            $display("FAIL post_reset seen_valid=%b level=%0d exp 0/0", seen, level_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_x0_backpressure();
        test_overflow();
        test_clear();
        test_wrap_async();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
